pmod_acl2_spi_responder: RTL
============================

// Module: pmod_acl2_spi_responder
// PURPOSE
//  SPI-target emulation of the ADXL362 as seen through the PMOD ACL2, for hardware loopback and
//  closed-loop simulation of the ACL2 custom driver. Decodes read (0x0B) and write (0x0A) bursts
//  from an SPI Mode-0 initiator, serves a 64-byte register map on CIPO, and drives INT1/INT2 levels
//  from STATUS and the INTMAP registers. Measurement and STATUS bytes come from the bench/top ports.
// PARAMETERS
//  parm_devid_ad   8'hAD  value of register 0x00
//  parm_devid_mst  8'h1D  value of register 0x01
//  parm_partid     8'hF2  value of register 0x02
//  parm_revid      8'h01  value of register 0x03
// PORTS
//  i_clk_20mhz   in   1   system clock; must be >= 8x SCK frequency
//  i_rstn_20mhz  in   1   asynchronous, active-low reset
//  ei_sck        in   1   SPI clock from initiator, async
//  ei_csn        in   1   SPI chip select, active low, async
//  ei_copi       in   1   SPI data in, async
//  eo_cipo_o     out  1   SPI data out
//  eo_cipo_t     out  1   tristate control, 1 = high-Z
//  eo_int1       out  1   INT1 level
//  eo_int2       out  1   INT2 level
//  i_meas_data   in   64  t_pmod_acl2_reg_8: registers 0x0E..0x15, byte 0x0E in [63:56]
//  i_status      in   8   register 0x0B
//  o_wr_valid    out  1   one-clock pulse per committed write byte
//  o_wr_addr     out  6   address of committed write
//  o_wr_data     out  8   data of committed write
//  o_soft_reset  out  1   one-clock pulse on write 0x52 to 0x1F
// BEHAVIOUR
//  Reset: eo_cipo_o=0, eo_cipo_t=1, eo_int1/2=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0,
//   o_soft_reset=0, config regs 0x20..0x2F=0x00, FSM=ST_IDLE.
//  Inputs pass 2-FF synchronizers. sck_rise/sck_fall/csn_fall/csn_rise are one-clock pulses from a
//   third registered stage.
//  Mode 0: COPI sampled on sck_rise, MSB first; CIPO changes on sck_fall. eo_cipo_o is registered,
//   so CIPO reaches the pin 4 clocks after the SCK pin falls.
//  eo_cipo_t=0 while synced csn is low, else 1.
//  FSM: ST_IDLE -csn_fall-> ST_CMD (bit count 0, i_meas_data latched into snapshot).
//   ST_CMD after 8 bits: 0x0A->ST_ADDR(wr), 0x0B->ST_ADDR(rd), other->ST_IGNORE.
//   ST_ADDR after 8 bits: addr<=byte[5:0] (bits [7:6] ignored) -> ST_DATA. For rd, the shift register
//   loads the byte at addr on that same sck_rise, and its MSB drives on the next sck_fall.
//   ST_DATA, per 8 bits:
//    - wr: commit byte at addr; pulse o_wr_valid.
//    - rd: load next byte.
//    - both: addr<=addr+1, wrapping 0x3F->0x00.
//   ST_IGNORE: CIPO held 0; no writes.
//   csn_rise in any state -> ST_IDLE next clock; partial byte discarded, bit count cleared.
//  Register map reads:
//   - 0x00..0x03: parameters.
//   - 0x0B: i_status, sampled at load time.
//   - 0x0E..0x15: snapshot, so a burst is coherent even if i_meas_data changes.
//   - 0x20..0x2F: stored config.
//   - all others: 0x00.
//  Writes: only 0x20..0x2F are stored; others are ignored but still pulse o_wr_valid. A write of 0x52
//   to 0x1F clears 0x20..0x2F on the commit clock and pulses o_soft_reset. Any other value written to
//   0x1F has no effect.
//  Interrupts, registered, 1 clock after a status/map change; INTMAP1=0x2A, INTMAP2=0x2B:
//   eo_intN = (|(INTMAPN[6:0] & i_status[6:0])) ^ INTMAPN[7].
//  Simultaneous sck_rise and csn_rise: csn_rise wins; the bit is dropped.
//  Reset mid-burst: immediate return to reset values; the initiator sees high-Z.
// STRUCTURE
//  pmod_stand_spi_solo_pkg gains:
//   - constants c_acl2_cmd_wr=8'h0A, c_acl2_cmd_rd=8'h0B, c_acl2_soft_reset_key=8'h52;
//   - register address constants;
//   - the t_acl2_resp_state enum (ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_IGNORE).
//  One sub-module: spi_resp_edge_sync (synchronizers plus edge pulses for sck/csn, synced copi).
//  FSM, shift registers, register file and interrupt logic stay in this module.
// TESTING (SCK = FCLK/8, Mode 0)
//  1. Read 0x0B,0x00 + 4 bytes -> CIPO returns AD 1D F2 01. eo_cipo_t=1 before and after CS.
//  2. Write 0x0A,0x20,FA,00,96 then read 0x0B,0x20 x3 -> FA 00 96; o_wr_valid pulses 3x,
//     o_wr_addr 0x20/21/22.
//  3. i_meas_data=64'h0123456789ABCDEF, read 0x0E x8, change input after byte 2 -> returns
//     01 23 45 67 89 AB CD EF.
//  4. Write 0x1F=0x52 -> o_soft_reset 1 clock; 0x20 reads back 00. Write 0x1F=0x51 -> no pulse,
//     config unchanged.
//  5. CS high after 5 bits of a data byte -> no write; command 0x0D + 3 bytes -> CIPO all 0,
//     no o_wr_valid.
//  6. INTMAP1=0x10, i_status=0x10 -> eo_int1=1. INTMAP1=0x90 -> eo_int1=0.
//     i_status=0x00 with INTMAP2=0x20 -> eo_int2=0.

Source files
------------

// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared definitions for the PMOD ACL2 (ADXL362) SPI responder.
// Contents:
//   - SPI command bytes and the soft-reset key
//   - register map addresses
//   - t_pmod_acl2_reg_8 : eight measurement bytes, element [7] = register 0x0E
//   - t_acl2_resp_state : responder FSM states
//   - is_cfg_addr()     : true for the stored config window 0x20..0x2F
package pmod_stand_spi_solo_pkg;

  localparam logic [7:0] c_acl2_cmd_wr         = 8'h0A;
  localparam logic [7:0] c_acl2_cmd_rd         = 8'h0B;
  localparam logic [7:0] c_acl2_soft_reset_key = 8'h52;

  localparam logic [5:0] c_acl2_addr_devid_ad  = 6'h00;
  localparam logic [5:0] c_acl2_addr_devid_mst = 6'h01;
  localparam logic [5:0] c_acl2_addr_partid    = 6'h02;
  localparam logic [5:0] c_acl2_addr_revid     = 6'h03;
  localparam logic [5:0] c_acl2_addr_status    = 6'h0B;
  localparam logic [5:0] c_acl2_addr_meas_lo   = 6'h0E;
  localparam logic [5:0] c_acl2_addr_meas_hi   = 6'h15;
  localparam logic [5:0] c_acl2_addr_soft_rst  = 6'h1F;
  localparam logic [5:0] c_acl2_addr_cfg_lo    = 6'h20;
  localparam logic [5:0] c_acl2_addr_intmap1   = 6'h2A;
  localparam logic [5:0] c_acl2_addr_intmap2   = 6'h2B;
  localparam logic [5:0] c_acl2_addr_cfg_hi    = 6'h2F;

  typedef logic [7:0][7:0] t_pmod_acl2_reg_8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } t_acl2_resp_state;

  // Config window 0x20..0x2F is exactly the addresses with [5:4] == 2'b10.
  function automatic logic is_cfg_addr(input logic [5:0] addr);
    return (addr[5:4] == 2'b10);
  endfunction

endpackage

// File: rtl/spi_resp_edge_sync.sv
// Brings the asynchronous SPI pins into the i_clk_20mhz domain.
// Every pin passes a 2-FF synchronizer; SCK and CSN get a third stage, and
// their edge pulses are registered from the 2nd/3rd stage comparison so each
// pulse is exactly one clock wide.
// Ports:
//   i_clk_20mhz, i_rstn_20mhz : clock, asynchronous active-low reset
//   ei_sck, ei_csn, ei_copi   : raw SPI pins
//   sck_rise, sck_fall        : one-clock SCK edge pulses
//   csn_fall, csn_rise        : one-clock CSN edge pulses
//   csn_sync                  : synchronized CSN level (aligned with pulses)
//   copi_sync                 : synchronized COPI level
module spi_resp_edge_sync (
  input  logic i_clk_20mhz,
  input  logic i_rstn_20mhz,
  input  logic ei_sck,
  input  logic ei_csn,
  input  logic ei_copi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csn_fall,
  output logic csn_rise,
  output logic csn_sync,
  output logic copi_sync
);

  localparam int n_chan = 3;
  // Idle levels, ordered {copi, csn, sck}: CSN idles high so no false
  // csn_fall appears when reset is released.
  localparam logic [n_chan-1:0] c_idle = 3'b010;

  logic [n_chan-1:0] pin_raw;
  logic [n_chan-1:0] pin_sync;

  assign pin_raw = {ei_copi, ei_csn, ei_sck};

  genvar gi;
  generate
    for (gi = 0; gi < n_chan; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
          meta_reg <= c_idle[gi];
          sync_reg <= c_idle[gi];
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  // Third stage for {csn, sck} plus the registered edge pulses.
  logic [1:0] dly_reg;
  logic       sck_rise_reg;
  logic       sck_fall_reg;
  logic       csn_fall_reg;
  logic       csn_rise_reg;

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      dly_reg      <= c_idle[1:0];
      sck_rise_reg <= 1'b0;
      sck_fall_reg <= 1'b0;
      csn_fall_reg <= 1'b0;
      csn_rise_reg <= 1'b0;
    end else begin
      dly_reg      <= pin_sync[1:0];
      sck_rise_reg <=  pin_sync[0] & ~dly_reg[0];
      sck_fall_reg <= ~pin_sync[0] &  dly_reg[0];
      csn_rise_reg <=  pin_sync[1] & ~dly_reg[1];
      csn_fall_reg <= ~pin_sync[1] &  dly_reg[1];
    end
  end

  assign sck_rise  = sck_rise_reg;
  assign sck_fall  = sck_fall_reg;
  assign csn_fall  = csn_fall_reg;
  assign csn_rise  = csn_rise_reg;
  assign csn_sync  = dly_reg[1];
  assign copi_sync = pin_sync[2];

endmodule

// File: rtl/pmod_acl2_spi_responder.sv
// SPI-target emulation of the ADXL362 behind a PMOD ACL2.
// Decodes Mode-0 read (0x0B) and write (0x0A) bursts, serves a 64-byte
// register map on CIPO and drives INT1/INT2 from STATUS and INTMAP1/2.
// Ports:
//   i_clk_20mhz, i_rstn_20mhz : clock (>= 8x SCK), asynchronous active-low reset
//   ei_sck, ei_csn, ei_copi   : SPI pins from the initiator (asynchronous)
//   eo_cipo_o, eo_cipo_t      : CIPO data and tristate control (1 = high-Z)
//   eo_int1, eo_int2          : interrupt levels
//   i_meas_data               : registers 0x0E..0x15, 0x0E in [63:56]
//   i_status                  : register 0x0B
//   o_wr_valid/addr/data      : one pulse per committed write byte
//   o_soft_reset              : pulse when 0x52 is written to 0x1F
module pmod_acl2_spi_responder
  import pmod_stand_spi_solo_pkg::*;
#(
  parameter logic [7:0] parm_devid_ad  = 8'hAD,
  parameter logic [7:0] parm_devid_mst = 8'h1D,
  parameter logic [7:0] parm_partid    = 8'hF2,
  parameter logic [7:0] parm_revid     = 8'h01
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        ei_sck,
  input  logic        ei_csn,
  input  logic        ei_copi,
  output logic        eo_cipo_o,
  output logic        eo_cipo_t,
  output logic        eo_int1,
  output logic        eo_int2,
  input  logic [63:0] i_meas_data,
  input  logic [7:0]  i_status,
  output logic        o_wr_valid,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_soft_reset
);

  logic sck_rise;
  logic sck_fall;
  logic csn_fall;
  logic csn_rise;
  logic csn_sync;
  logic copi_sync;

  spi_resp_edge_sync u_edge_sync (
    .i_clk_20mhz (i_clk_20mhz),
    .i_rstn_20mhz(i_rstn_20mhz),
    .ei_sck      (ei_sck),
    .ei_csn      (ei_csn),
    .ei_copi     (ei_copi),
    .sck_rise    (sck_rise),
    .sck_fall    (sck_fall),
    .csn_fall    (csn_fall),
    .csn_rise    (csn_rise),
    .csn_sync    (csn_sync),
    .copi_sync   (copi_sync)
  );

  t_acl2_resp_state state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [6:0]       shift_in_reg;
  logic [7:0]       shift_out_reg;
  logic             is_wr_reg;
  logic [5:0]       addr_reg;
  t_pmod_acl2_reg_8 snap_reg;
  logic [7:0]       cfg_reg [16];
  logic             cipo_o_reg;
  logic             cipo_t_reg;
  logic             int1_reg;
  logic             int2_reg;
  logic             wr_valid_reg;
  logic [5:0]       wr_addr_reg;
  logic [7:0]       wr_data_reg;
  logic             soft_reset_reg;

  // The byte as it stands once the current COPI bit is shifted in.
  logic [7:0] byte_next;
  logic       byte_done;
  logic [5:0] lookup_addr;
  logic [2:0] meas_idx;
  logic [7:0] rd_byte;

  assign byte_next = {shift_in_reg, copi_sync};
  assign byte_done = (bit_cnt_reg == 3'd7);

  // Only two places load the read shifter: end of the address byte (the
  // address just received) and end of a data byte (the following address).
  assign lookup_addr = (state_reg == ST_ADDR) ? byte_next[5:0] : addr_reg + 6'd1;
  assign meas_idx    = 3'(lookup_addr - c_acl2_addr_meas_lo);

  always_comb begin
    rd_byte = 8'h00;
    if (lookup_addr == c_acl2_addr_devid_ad) begin
      rd_byte = parm_devid_ad;
    end else if (lookup_addr == c_acl2_addr_devid_mst) begin
      rd_byte = parm_devid_mst;
    end else if (lookup_addr == c_acl2_addr_partid) begin
      rd_byte = parm_partid;
    end else if (lookup_addr == c_acl2_addr_revid) begin
      rd_byte = parm_revid;
    end else if (lookup_addr == c_acl2_addr_status) begin
      rd_byte = i_status;
    end else if (lookup_addr >= c_acl2_addr_meas_lo && lookup_addr <= c_acl2_addr_meas_hi) begin
      rd_byte = snap_reg[3'd7 - meas_idx];
    end else if (is_cfg_addr(lookup_addr)) begin
      rd_byte = cfg_reg[lookup_addr[3:0]];
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_in_reg   <= 7'd0;
      shift_out_reg  <= 8'h00;
      is_wr_reg      <= 1'b0;
      addr_reg       <= 6'd0;
      snap_reg       <= '0;
      cipo_o_reg     <= 1'b0;
      cipo_t_reg     <= 1'b1;
      int1_reg       <= 1'b0;
      int2_reg       <= 1'b0;
      wr_valid_reg   <= 1'b0;
      wr_addr_reg    <= 6'd0;
      wr_data_reg    <= 8'h00;
      soft_reset_reg <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cfg_reg[i] <= 8'h00;
      end
    end else begin
      wr_valid_reg   <= 1'b0;
      soft_reset_reg <= 1'b0;
      cipo_t_reg     <= csn_sync;

      // Bit 7 of INTMAPn inverts the output (active-low interrupt).
      int1_reg <= (|(cfg_reg[c_acl2_addr_intmap1[3:0]][6:0] & i_status[6:0]))
                  ^ cfg_reg[c_acl2_addr_intmap1[3:0]][7];
      int2_reg <= (|(cfg_reg[c_acl2_addr_intmap2[3:0]][6:0] & i_status[6:0]))
                  ^ cfg_reg[c_acl2_addr_intmap2[3:0]][7];

      if (csn_rise) begin
        // Chip-select release beats a coincident SCK edge; partial bytes die here.
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 3'd0;
        cipo_o_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (csn_fall) begin
              state_reg   <= ST_CMD;
              bit_cnt_reg <= 3'd0;
              snap_reg    <= i_meas_data;
            end
          end

          ST_CMD: begin
            if (sck_fall) begin
              cipo_o_reg <= 1'b0;
            end
            if (sck_rise) begin
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              shift_in_reg <= byte_next[6:0];
              if (byte_done) begin
                if (byte_next == c_acl2_cmd_wr) begin
                  state_reg <= ST_ADDR;
                  is_wr_reg <= 1'b1;
                end else if (byte_next == c_acl2_cmd_rd) begin
                  state_reg <= ST_ADDR;
                  is_wr_reg <= 1'b0;
                end else begin
                  state_reg <= ST_IGNORE;
                end
              end
            end
          end

          ST_ADDR: begin
            if (sck_fall) begin
              cipo_o_reg <= 1'b0;
            end
            if (sck_rise) begin
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              shift_in_reg <= byte_next[6:0];
              if (byte_done) begin
                addr_reg  <= byte_next[5:0];
                state_reg <= ST_DATA;
                if (!is_wr_reg) begin
                  shift_out_reg <= rd_byte;
                end
              end
            end
          end

          ST_DATA: begin
            if (sck_fall) begin
              if (is_wr_reg) begin
                cipo_o_reg <= 1'b0;
              end else begin
                cipo_o_reg    <= shift_out_reg[7];
                shift_out_reg <= {shift_out_reg[6:0], 1'b0};
              end
            end
            if (sck_rise) begin
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              shift_in_reg <= byte_next[6:0];
              if (byte_done) begin
                addr_reg <= addr_reg + 6'd1;
                if (is_wr_reg) begin
                  wr_valid_reg <= 1'b1;
                  wr_addr_reg  <= addr_reg;
                  wr_data_reg  <= byte_next;
                  if (is_cfg_addr(addr_reg)) begin
                    cfg_reg[addr_reg[3:0]] <= byte_next;
                  end else if (addr_reg == c_acl2_addr_soft_rst &&
                               byte_next == c_acl2_soft_reset_key) begin
                    soft_reset_reg <= 1'b1;
                    for (int i = 0; i < 16; i++) begin
                      cfg_reg[i] <= 8'h00;
                    end
                  end
                end else begin
                  shift_out_reg <= rd_byte;
                end
              end
            end
          end

          ST_IGNORE: begin
            cipo_o_reg <= 1'b0;
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign eo_cipo_o    = cipo_o_reg;
  assign eo_cipo_t    = cipo_t_reg;
  assign eo_int1      = int1_reg;
  assign eo_int2      = int2_reg;
  assign o_wr_valid   = wr_valid_reg;
  assign o_wr_addr    = wr_addr_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_soft_reset = soft_reset_reg;

endmodule
